// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: decode-stage interlock and X-stage operand forwarding for a
// five-stage pipeline (F/D/X/M/W). Detects load-use hazards and, optionally,
// HI/LO result hazards behind a multi-cycle MULT/DIV unit. It also registers the
// X-stage operand selects, drives the M-stage store-data bypass and keeps a
// saturating count of stall cycles.
// Build option: define HAZ_MULDIV_INTERLOCK_EN to enable the MULT/DIV interlock.
// Without it, mdu_busy is tied to 0 and x_muldiv_issue/x_is_div are ignored.
module hazard_fwd_unit #(
   parameter int REG_W    = 5,
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 32,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [REG_W-1:0] d_rs,
   input  logic [REG_W-1:0] d_rt,
   input  logic             d_use_rs,
   input  logic             d_use_rt,
   input  logic             d_is_store,
   input  logic             d_is_hilo_rd,
   input  logic             d_is_muldiv,
   input  logic [REG_W-1:0] dx_rd,
   input  logic [REG_W-1:0] xm_rd,
   input  logic [REG_W-1:0] mw_rd,
   input  logic             dx_rwe,
   input  logic             xm_rwe,
   input  logic             mw_rwe,
   input  logic             dx_is_load,
   input  logic             xm_is_store,
   input  logic [REG_W-1:0] xm_rt,
   input  logic             do_branch,
   input  logic             x_muldiv_issue,
   input  logic             x_is_div,
   output logic             stall,
   output logic             flush_dx,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             wm_bypass,
   output logic             mdu_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int               MDU_W    = 6;
   localparam logic [REG_W-1:0] ZERO_REG = {REG_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic       load_use_s;
   logic       mdu_stall_s;
   logic [1:0] fwd_a_nxt_s;
   logic [1:0] fwd_b_nxt_s;

   // Operand select for one source: MX (01) beats WX (10); register 0 is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_W-1:0] src,
      input logic             use_src,
      input logic [REG_W-1:0] dx_dst,
      input logic             dx_we,
      input logic [REG_W-1:0] xm_dst,
      input logic             xm_we
   );
      logic [1:0] sel;
      if (use_src && (src != ZERO_REG) && dx_we && (dx_dst == src)) begin
         sel = 2'b01;
      end else if (use_src && (src != ZERO_REG) && xm_we && (xm_dst == src)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Load-use detection: a load in DX whose result a D source needs next cycle.
   // The rt of a store is exempt because the W->M bypass supplies the store data later.
   always_comb begin
      load_use_s = 1'b0;
      if (dx_rwe && dx_is_load && (dx_rd != ZERO_REG)) begin
         load_use_s = (d_use_rs && (d_rs == dx_rd)) ||
                      (d_use_rt && (d_rt == dx_rd) && !d_is_store);
      end else begin
         load_use_s = 1'b0;
      end
   end

   // A taken branch squashes the D instruction, so it overrides any stall.
   assign stall     = (load_use_s | mdu_stall_s) & ~do_branch;
   assign flush_dx  = do_branch | load_use_s | mdu_stall_s;
   assign wm_bypass = xm_is_store & mw_rwe & (mw_rd == xm_rt) & (mw_rd != ZERO_REG);

   // Next forwarding selects; a bubble entering DX carries no forwarding.
   always_comb begin
      fwd_a_nxt_s = 2'b00;
      fwd_b_nxt_s = 2'b00;
      if (flush_dx) begin
         fwd_a_nxt_s = 2'b00;
         fwd_b_nxt_s = 2'b00;
      end else begin
         fwd_a_nxt_s = fwd_sel(d_rs, d_use_rs, dx_rd, dx_rwe, xm_rd, xm_rwe);
         fwd_b_nxt_s = fwd_sel(d_rt, d_use_rt, dx_rd, dx_rwe, xm_rd, xm_rwe);
      end
   end

   // Register the X-stage operand selects.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fwd_a <= 2'b00;
         fwd_b <= 2'b00;
      end else begin
         fwd_a <= fwd_a_nxt_s;
         fwd_b <= fwd_b_nxt_s;
      end
   end

   // Saturating stall-cycle counter; it holds at all-ones instead of wrapping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cnt <= {CNT_W{1'b0}};
      end else if (stall && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
         stall_cnt <= stall_cnt;
      end
   end

`ifdef HAZ_MULDIV_INTERLOCK_EN
   logic [MDU_W-1:0] mdu_cnt_r;
   logic [MDU_W-1:0] mdu_cnt_nxt_s;

   // MDU down-counter: a new issue reloads it (even while busy); otherwise it counts down to zero.
   always_comb begin
      mdu_cnt_nxt_s = mdu_cnt_r;
      if (x_muldiv_issue) begin
         if (x_is_div) begin
            mdu_cnt_nxt_s = MDU_W'(DIV_LAT);
         end else begin
            mdu_cnt_nxt_s = MDU_W'(MULT_LAT);
         end
      end else if (mdu_cnt_r != {MDU_W{1'b0}}) begin
         mdu_cnt_nxt_s = mdu_cnt_r - {{(MDU_W-1){1'b0}}, 1'b1};
      end else begin
         mdu_cnt_nxt_s = mdu_cnt_r;
      end
   end

   // Register the counter and a busy flag that tracks (counter != 0).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mdu_cnt_r <= {MDU_W{1'b0}};
         mdu_busy  <= 1'b0;
      end else begin
         mdu_cnt_r <= mdu_cnt_nxt_s;
         mdu_busy  <= (mdu_cnt_nxt_s != {MDU_W{1'b0}});
      end
   end

   assign mdu_stall_s = mdu_busy & (d_is_hilo_rd | d_is_muldiv);
`else
   logic unused_mdu_s;

   assign mdu_busy     = 1'b0;
   assign mdu_stall_s  = 1'b0;
   assign unused_mdu_s = x_muldiv_issue ^ x_is_div ^ d_is_hilo_rd ^ d_is_muldiv;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: table-driven directed vectors for hazard_fwd_unit,
// followed by hand-written multi-cycle sequences (load-use, store bypass,
// MULT/DIV interlock, reset during a MULT).
module tb_hazard_fwd_unit;
   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  d_rs, d_rt, dx_rd, xm_rd, mw_rd, xm_rt;
   logic        d_use_rs, d_use_rt, d_is_store, d_is_hilo_rd, d_is_muldiv;
   logic        dx_rwe, xm_rwe, mw_rwe, dx_is_load, xm_is_store, do_branch;
   logic        x_muldiv_issue, x_is_div;
   logic        stall, flush_dx, wm_bypass, mdu_busy;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;
   int n_stall;

   typedef struct {
      logic [4:0] d_rs;
      logic [4:0] d_rt;
      logic       d_use_rs;
      logic       d_use_rt;
      logic       d_is_store;
      logic [4:0] dx_rd;
      logic       dx_rwe;
      logic       dx_is_load;
      logic [4:0] xm_rd;
      logic       xm_rwe;
      logic       xm_is_store;
      logic [4:0] xm_rt;
      logic [4:0] mw_rd;
      logic       mw_rwe;
      logic       do_branch;
      logic       e_stall;
      logic       e_flush;
      logic [1:0] e_fa;
      logic [1:0] e_fb;
      logic       e_wm;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   hazard_fwd_unit #(.REG_W(5), .MULT_LAT(4), .DIV_LAT(32), .CNT_W(16)) dut (
      .clock(clock), .reset(reset),
      .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
      .d_is_store(d_is_store), .d_is_hilo_rd(d_is_hilo_rd), .d_is_muldiv(d_is_muldiv),
      .dx_rd(dx_rd), .xm_rd(xm_rd), .mw_rd(mw_rd),
      .dx_rwe(dx_rwe), .xm_rwe(xm_rwe), .mw_rwe(mw_rwe),
      .dx_is_load(dx_is_load), .xm_is_store(xm_is_store), .xm_rt(xm_rt),
      .do_branch(do_branch), .x_muldiv_issue(x_muldiv_issue), .x_is_div(x_is_div),
      .stall(stall), .flush_dx(flush_dx), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .wm_bypass(wm_bypass), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic idle();
      d_rs = 5'd0; d_rt = 5'd0; d_use_rs = 1'b0; d_use_rt = 1'b0;
      d_is_store = 1'b0; d_is_hilo_rd = 1'b0; d_is_muldiv = 1'b0;
      dx_rd = 5'd0; xm_rd = 5'd0; mw_rd = 5'd0; xm_rt = 5'd0;
      dx_rwe = 1'b0; xm_rwe = 1'b0; mw_rwe = 1'b0;
      dx_is_load = 1'b0; xm_is_store = 1'b0; do_branch = 1'b0;
      x_muldiv_issue = 1'b0; x_is_div = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      idle();
      d_rs = v.d_rs; d_rt = v.d_rt; d_use_rs = v.d_use_rs; d_use_rt = v.d_use_rt;
      d_is_store = v.d_is_store; dx_rd = v.dx_rd; dx_rwe = v.dx_rwe;
      dx_is_load = v.dx_is_load; xm_rd = v.xm_rd; xm_rwe = v.xm_rwe;
      xm_is_store = v.xm_is_store; xm_rt = v.xm_rt; mw_rd = v.mw_rd;
      mw_rwe = v.mw_rwe; do_branch = v.do_branch;
   endtask

   initial begin
      reset = 1'b1;
      idle();

      vecs[0]  = '{default: '0};
      vecs[1]  = '{dx_rd: 5'd8, dx_rwe: 1'b1, dx_is_load: 1'b1, d_rs: 5'd8, d_use_rs: 1'b1,
                   e_stall: 1'b1, e_flush: 1'b1, default: '0};
      vecs[2]  = '{dx_rd: 5'd8, dx_rwe: 1'b1, dx_is_load: 1'b1, d_rs: 5'd3, d_use_rs: 1'b1,
                   d_rt: 5'd8, d_use_rt: 1'b1, e_stall: 1'b1, e_flush: 1'b1, default: '0};
      vecs[3]  = '{dx_rd: 5'd8, dx_rwe: 1'b1, dx_is_load: 1'b1, d_rt: 5'd8, d_use_rt: 1'b1,
                   d_is_store: 1'b1, e_fb: 2'b01, default: '0};
      vecs[4]  = '{dx_rd: 5'd5, dx_rwe: 1'b1, xm_rd: 5'd5, xm_rwe: 1'b1, d_rs: 5'd5,
                   d_use_rs: 1'b1, d_rt: 5'd5, d_use_rt: 1'b1, e_fa: 2'b01, e_fb: 2'b01,
                   default: '0};
      vecs[5]  = '{dx_rwe: 1'b1, xm_rwe: 1'b1, d_use_rs: 1'b1, d_use_rt: 1'b1, default: '0};
      vecs[6]  = '{dx_rd: 5'd9, dx_rwe: 1'b1, xm_rd: 5'd7, xm_rwe: 1'b1, d_rs: 5'd7,
                   d_use_rs: 1'b1, d_rt: 5'd9, d_use_rt: 1'b1, e_fa: 2'b10, e_fb: 2'b01,
                   default: '0};
      vecs[7]  = '{dx_rd: 5'd7, xm_rd: 5'd7, d_rs: 5'd7, d_use_rs: 1'b1, default: '0};
      vecs[8]  = '{dx_rd: 5'd5, dx_rwe: 1'b1, d_rs: 5'd5, d_rt: 5'd5, default: '0};
      vecs[9]  = '{xm_is_store: 1'b1, xm_rt: 5'd8, mw_rd: 5'd8, mw_rwe: 1'b1, e_wm: 1'b1,
                   default: '0};
      vecs[10] = '{xm_is_store: 1'b1, mw_rwe: 1'b1, default: '0};
      vecs[11] = '{xm_is_store: 1'b1, xm_rt: 5'd8, mw_rd: 5'd8, default: '0};
      vecs[12] = '{dx_rd: 5'd8, dx_rwe: 1'b1, dx_is_load: 1'b1, d_rs: 5'd8, d_use_rs: 1'b1,
                   do_branch: 1'b1, e_flush: 1'b1, default: '0};
      vecs[13] = '{dx_rd: 5'd5, dx_rwe: 1'b1, d_rs: 5'd5, d_use_rs: 1'b1, do_branch: 1'b1,
                   e_flush: 1'b1, default: '0};
      vecs[14] = '{dx_rwe: 1'b1, dx_is_load: 1'b1, d_use_rs: 1'b1, default: '0};
      vecs[15] = '{dx_rd: 5'd8, dx_is_load: 1'b1, d_rs: 5'd8, d_use_rs: 1'b1, default: '0};
      vecs[16] = '{dx_rd: 5'd8, dx_rwe: 1'b1, dx_is_load: 1'b1, d_rs: 5'd9, d_use_rs: 1'b1,
                   xm_rd: 5'd9, xm_rwe: 1'b1, e_fa: 2'b10, default: '0};
      vecs[17] = '{mw_rd: 5'd4, mw_rwe: 1'b1, d_rs: 5'd4, d_use_rs: 1'b1, default: '0};
      vecs[18] = '{xm_rd: 5'd3, xm_rwe: 1'b1, d_rt: 5'd3, d_use_rt: 1'b1, e_fb: 2'b10,
                   default: '0};
      vecs[19] = '{xm_rt: 5'd8, mw_rd: 5'd8, mw_rwe: 1'b1, default: '0};

      // Reset state
      #2;
      chk("rst_fwd_a", 32'(fwd_a), 32'd0);
      chk("rst_fwd_b", 32'(fwd_b), 32'd0);
      chk("rst_mdu_busy", 32'(mdu_busy), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_flush", 32'(flush_dx), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < NV; i++) begin
         @(negedge clock);
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
         chk($sformatf("v%0d_flush", i), 32'(flush_dx), 32'(vecs[i].e_flush));
         chk($sformatf("v%0d_wm", i), 32'(wm_bypass), 32'(vecs[i].e_wm));
         @(posedge clock);
         #1;
         if (vecs[i].e_stall) exp_cnt++;
         chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a), 32'(vecs[i].e_fa));
         chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b), 32'(vecs[i].e_fb));
         chk($sformatf("v%0d_cnt", i), 32'(stall_cnt), 32'(exp_cnt));
      end

      // Load-use bubble, then the load forwards from XM (WX)
      @(negedge clock);
      idle();
      dx_rd = 5'd8; dx_rwe = 1'b1; dx_is_load = 1'b1; d_rs = 5'd8; d_use_rs = 1'b1;
      #1;
      chk("lu_stall", 32'(stall), 32'd1);
      chk("lu_flush", 32'(flush_dx), 32'd1);
      @(posedge clock);
      #1;
      exp_cnt++;
      chk("lu_cnt", 32'(stall_cnt), 32'(exp_cnt));
      @(negedge clock);
      dx_rd = 5'd0; dx_rwe = 1'b0; dx_is_load = 1'b0; xm_rd = 5'd8; xm_rwe = 1'b1;
      #1;
      chk("lu_after_stall", 32'(stall), 32'd0);
      @(posedge clock);
      #1;
      chk("lu_after_fwd_a", 32'(fwd_a), 32'd2);
      chk("lu_after_cnt", 32'(stall_cnt), 32'(exp_cnt));

      // Store exemption, then the W->M store-data bypass two cycles later
      @(negedge clock);
      idle();
      dx_rd = 5'd8; dx_rwe = 1'b1; dx_is_load = 1'b1;
      d_rt = 5'd8; d_use_rt = 1'b1; d_is_store = 1'b1;
      #1;
      chk("st_stall", 32'(stall), 32'd0);
      @(negedge clock);
      idle();
      xm_rd = 5'd8; xm_rwe = 1'b1;
      @(negedge clock);
      idle();
      xm_is_store = 1'b1; xm_rt = 5'd8; mw_rd = 5'd8; mw_rwe = 1'b1;
      #1;
      chk("st_wm_bypass", 32'(wm_bypass), 32'd1);
      chk("st_cnt", 32'(stall_cnt), 32'(exp_cnt));

`ifdef HAZ_MULDIV_INTERLOCK_EN
      // DIV interlock: a HI/LO read stalls for exactly DIV_LAT cycles
      @(negedge clock);
      idle();
      x_muldiv_issue = 1'b1; x_is_div = 1'b1;
      @(negedge clock);
      idle();
      d_is_hilo_rd = 1'b1;
      n_stall = 0;
      for (int k = 0; k < 100; k++) begin
         #1;
         if (stall !== 1'b1) break;
         n_stall++;
         exp_cnt++;
         @(negedge clock);
      end
      chk("div_stall_cycles", 32'(n_stall), 32'd32);
      chk("div_cnt", 32'(stall_cnt), 32'(exp_cnt));
      chk("div_busy_done", 32'(mdu_busy), 32'd0);

      // MULT reissued as DIV while busy: the reissue reloads the counter
      @(negedge clock);
      idle();
      x_muldiv_issue = 1'b1;
      @(negedge clock);
      x_is_div = 1'b1;
      @(negedge clock);
      idle();
      d_is_muldiv = 1'b1;
      n_stall = 0;
      for (int k = 0; k < 100; k++) begin
         #1;
         if (stall !== 1'b1) break;
         n_stall++;
         exp_cnt++;
         @(negedge clock);
      end
      chk("reissue_stall_cycles", 32'(n_stall), 32'd32);

      // Plain MULT: stall for MULT_LAT cycles
      @(negedge clock);
      idle();
      x_muldiv_issue = 1'b1;
      @(negedge clock);
      idle();
      d_is_muldiv = 1'b1;
      n_stall = 0;
      for (int k = 0; k < 100; k++) begin
         #1;
         if (stall !== 1'b1) break;
         n_stall++;
         exp_cnt++;
         @(negedge clock);
      end
      chk("mult_stall_cycles", 32'(n_stall), 32'd4);
      chk("mult_cnt", 32'(stall_cnt), 32'(exp_cnt));
`else
      // Without the interlock, MULT/DIV issue never stalls a HI/LO read
      @(negedge clock);
      idle();
      x_muldiv_issue = 1'b1; x_is_div = 1'b1;
      @(negedge clock);
      idle();
      d_is_hilo_rd = 1'b1; d_is_muldiv = 1'b1;
      #1;
      chk("nomdu_stall", 32'(stall), 32'd0);
      chk("nomdu_busy", 32'(mdu_busy), 32'd0);
      chk("nomdu_cnt", 32'(stall_cnt), 32'(exp_cnt));
`endif

      // Reset three cycles into a MULT
      @(negedge clock);
      idle();
      x_muldiv_issue = 1'b1;
      @(negedge clock);
      idle();
      @(negedge clock);
      @(negedge clock);
`ifdef HAZ_MULDIV_INTERLOCK_EN
      #1;
      chk("mid_mult_busy", 32'(mdu_busy), 32'd1);
`endif
      dx_rd = 5'd6; dx_rwe = 1'b1; d_rs = 5'd6; d_use_rs = 1'b1;
      @(posedge clock);
      #1;
      chk("pre_rst_fwd_a", 32'(fwd_a), 32'd1);
      @(negedge clock);
      idle();
      reset = 1'b1;
      #1;
      exp_cnt = 0;
      chk("async_rst_busy", 32'(mdu_busy), 32'd0);
      chk("async_rst_cnt", 32'(stall_cnt), 32'd0);
      chk("async_rst_fwd_a", 32'(fwd_a), 32'd0);
      dx_rd = 5'd8; dx_rwe = 1'b1; dx_is_load = 1'b1; d_rs = 5'd8; d_use_rs = 1'b1;
      #1;
      chk("rst_load_use_stall", 32'(stall), 32'd1);
      @(posedge clock);
      #1;
      chk("rst_hold_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clock);
      idle();
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("post_rst_busy", 32'(mdu_busy), 32'd0);
      chk("post_rst_cnt", 32'(stall_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
